video_in_ctrl: RTL and testbench

- Frame-capture controller behind the video input pixel FIFO.
- Waits for the start of a frame, then drains packed pixel words (4 × 8-bit pixels per 32-bit word) from a first-word-fall-through FIFO.
- Issues fixed-length write bursts to the memory bus master, alternating between two frame buffers (double buffering).
- Software controls it through an enable bit and two base addresses. It reports frame completion and overruns.

---
 rtl/video_in_ctrl.sv | 171 +++++++++++++++++
 tb/tb_video_in_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_in_ctrl.sv
// Frame-capture controller: waits for a frame start, drains packed pixel
// words from an FWFT FIFO and writes them to memory in fixed-length bursts,
// alternating between two frame buffers.
//
// Handshakes:
//   FIFO  : a word is popped (fifo_re) exactly when a beat is accepted,
//           i.e. wvalid & wready. fifo_dout is presented as wdata unchanged.
//   Bus   : req stays high in REQ until a one-cycle gnt. req is decoded from
//           state, so it drops the cycle after gnt. There is no combinational
//           path from gnt to req.
//   Write : a beat transfers on every cycle with wvalid & wready. While
//           stalled, wdata follows the FIFO head, which does not move.
//           addr holds from req rise through the last beat.
module video_in_ctrl #(
   parameter int p_WIDTH  = 640,
   parameter int p_HEIGHT = 480,
   parameter int p_BURST  = 16,
   parameter int p_CNT_W  = 10
) (
   input  logic               clk,
   input  logic               RST,
   input  logic               enable,
   input  logic [31:0]        buf_addr0,
   input  logic [31:0]        buf_addr1,
   input  logic               frame_valid,
   input  logic [p_CNT_W-1:0] fifo_count,
   input  logic [31:0]        fifo_dout,
   output logic               fifo_re,
   output logic               req,
   input  logic               gnt,
   output logic [31:0]        addr,
   output logic [31:0]        wdata,
   output logic               wvalid,
   input  logic               wready,
   output logic               cur_buf,
   output logic               busy,
   output logic               frame_done,
   output logic               frame_overrun
);

   localparam int          BEAT_W      = $clog2(p_BURST) + 1;
   localparam logic [31:0] FRAME_WORDS = 32'(p_WIDTH * p_HEIGHT / 4);
   localparam logic [31:0] BURST_LEN   = 32'(p_BURST);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(p_BURST - 1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_FRAME = 3'd1;
   localparam logic [2:0] S_WAIT_DATA  = 3'd2;
   localparam logic [2:0] S_REQ        = 3'd3;
   localparam logic [2:0] S_BURST      = 3'd4;
   localparam logic [2:0] S_DONE       = 3'd5;

   logic [2:0]        state_q, state_d;
   logic              frame_valid_q;
   logic              cur_buf_q, cur_buf_d;
   logic [31:0]       base_q, base_d;
   logic [31:0]       offset_q, offset_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [31:0]       addr_q, addr_d;
   logic              overrun_q, overrun_d;

   logic              fs;
   logic              busy_int;
   logic [31:0]       offset_inc;
   logic [31:0]       fifo_count_ext;

   // Output decode and frame-start edge detection.
   always_comb begin
      fs             = frame_valid & ~frame_valid_q;
      busy_int       = (state_q == S_WAIT_DATA) || (state_q == S_REQ) ||
                       (state_q == S_BURST)     || (state_q == S_DONE);
      offset_inc     = offset_q + 32'd1;
      fifo_count_ext = 32'(fifo_count);
   end

   assign req           = (state_q == S_REQ);
   assign wvalid        = (state_q == S_BURST);
   assign frame_done    = (state_q == S_DONE);
   assign fifo_re       = wvalid & wready;
   assign wdata         = fifo_dout;
   assign addr          = addr_q;
   assign cur_buf       = cur_buf_q;
   assign busy          = busy_int;
   assign frame_overrun = overrun_q;

   // Next-state logic: frame sequencing, burst counting and address generation.
   always_comb begin
      state_d   = state_q;
      cur_buf_d = cur_buf_q;
      base_d    = base_q;
      offset_d  = offset_q;
      beat_d    = beat_q;
      addr_d    = addr_q;
      overrun_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_WAIT_FRAME;
         end
         S_WAIT_FRAME: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (fs) begin
               // The new buffer is the opposite of the one just used.
               cur_buf_d = ~cur_buf_q;
               base_d    = cur_buf_q ? buf_addr0 : buf_addr1;
               offset_d  = 32'd0;
               addr_d    = base_d;
               state_d   = S_WAIT_DATA;
            end
         end
         S_WAIT_DATA: begin
            if (fifo_count_ext >= BURST_LEN) state_d = S_REQ;
         end
         S_REQ: begin
            if (gnt) begin
               beat_d  = '0;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (wready) begin
               beat_d   = beat_q + 1'b1;
               offset_d = offset_inc;
               if (beat_q == LAST_BEAT) begin
                  if (offset_inc == FRAME_WORDS) begin
                     state_d = S_DONE;
                  end else begin
                     // Next burst address is fixed here, on WAIT_DATA entry.
                     addr_d  = base_q + (offset_inc << 2);
                     state_d = S_WAIT_DATA;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = enable ? S_WAIT_FRAME : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A frame start while a frame is still being written is dropped.
      if (fs && busy_int) overrun_d = 1'b1;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q       <= S_IDLE;
         frame_valid_q <= 1'b0;
         cur_buf_q     <= 1'b1;
         base_q        <= 32'd0;
         offset_q      <= 32'd0;
         beat_q        <= '0;
         addr_q        <= 32'd0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_valid_q <= frame_valid;
         cur_buf_q     <= cur_buf_d;
         base_q        <= base_d;
         offset_q      <= offset_d;
         beat_q        <= beat_d;
         addr_q        <= addr_d;
         overrun_q     <= overrun_d;
      end
   end

endmodule

// File: tb/tb_video_in_ctrl.sv
// Directed bench for video_in_ctrl with an 8x4 frame and 2-word bursts.
module tb_video_in_ctrl;

   localparam int P_W = 8;
   localparam int P_H = 4;
   localparam int P_B = 2;
   localparam int P_C = 10;

   logic        clk;
   logic        RST;
   logic        enable;
   logic [31:0] buf_addr0;
   logic [31:0] buf_addr1;
   logic        frame_valid;
   logic [9:0]  fifo_count;
   logic [31:0] fifo_dout;
   logic        fifo_re;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wvalid;
   logic        wready;
   logic        cur_buf;
   logic        busy;
   logic        frame_done;
   logic        frame_overrun;

   int total = 0;
   int bad   = 0;
   int re_cnt   = 0;
   int done_cnt = 0;
   int ovr_cnt  = 0;

   video_in_ctrl #(
      .p_WIDTH (P_W),
      .p_HEIGHT(P_H),
      .p_BURST (P_B),
      .p_CNT_W (P_C)
   ) dut (
      .clk          (clk),
      .RST          (RST),
      .enable       (enable),
      .buf_addr0    (buf_addr0),
      .buf_addr1    (buf_addr1),
      .frame_valid  (frame_valid),
      .fifo_count   (fifo_count),
      .fifo_dout    (fifo_dout),
      .fifo_re      (fifo_re),
      .req          (req),
      .gnt          (gnt),
      .addr         (addr),
      .wdata        (wdata),
      .wvalid       (wvalid),
      .wready       (wready),
      .cur_buf      (cur_buf),
      .busy         (busy),
      .frame_done   (frame_done),
      .frame_overrun(frame_overrun)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pulse counters sampled on the falling edge, away from input changes.
   always @(negedge clk) begin
      if (fifo_re === 1'b1)       re_cnt++;
      if (frame_done === 1'b1)    done_cnt++;
      if (frame_overrun === 1'b1) ovr_cnt++;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait for req, grant two cycles later, run the burst with wready held.
   task automatic run_burst(input logic [31:0] exp_addr, input bit fv_rise);
      int n;
      n = 0;
      while (req !== 1'b1 && n < 50) begin
         cyc();
         n++;
      end
      check("req_rise", req, 1);
      check("burst_addr", addr, exp_addr);
      cyc();
      cyc();
      gnt = 1'b1;
      cyc();
      gnt = 1'b0;
      if (fv_rise) frame_valid = 1'b1;
      #1;
      check("req_drop", req, 0);
      check("wvalid_on", wvalid, 1);
      n = 0;
      while (wvalid === 1'b1 && n < 50) begin
         check("addr_hold", addr, exp_addr);
         cyc();
         n++;
      end
      check("beat_cycles", n, P_B);
   endtask

   // Run a full 4-burst frame starting in WAIT_DATA.
   task automatic run_frame(input logic [31:0] base);
      int re0;
      int done0;
      re0   = re_cnt;
      done0 = done_cnt;
      for (int i = 0; i < 4; i++) begin
         run_burst(base + 32'(8 * i), 1'b0);
      end
      check("frame_done_hi", frame_done, 1);
      cyc();
      check("frame_done_lo", frame_done, 0);
      check("frame_re_count", re_cnt - re0, 8);
      check("frame_done_count", done_cnt - done0, 1);
   endtask

   initial begin
      int re0;
      int ovr0;
      RST         = 1'b1;
      enable      = 1'b0;
      buf_addr0   = 32'h0000_1000;
      buf_addr1   = 32'h0000_2000;
      frame_valid = 1'b0;
      fifo_count  = 10'd4;
      fifo_dout   = 32'hA5A5_0000;
      gnt         = 1'b0;
      wready      = 1'b1;

      // Reset state.
      cyc(); cyc(); cyc();
      #1;
      check("rst_req", req, 0);
      check("rst_wvalid", wvalid, 0);
      check("rst_fifo_re", fifo_re, 0);
      check("rst_done", frame_done, 0);
      check("rst_ovr", frame_overrun, 0);
      check("rst_cur_buf", cur_buf, 1);
      check("rst_busy", busy, 0);

      // Frame 1: buffer 0.
      RST    = 1'b0;
      enable = 1'b1;
      cyc();
      cyc();
      check("wait_frame_busy", busy, 0);
      frame_valid = 1'b1;
      cyc();
      #1;
      check("f1_cur_buf", cur_buf, 0);
      check("f1_busy", busy, 1);
      run_frame(32'h0000_1000);
      check("f1_cur_buf_end", cur_buf, 0);

      // Frame 2: buffer 1.
      frame_valid = 1'b0;
      cyc();
      frame_valid = 1'b1;
      cyc();
      #1;
      check("f2_cur_buf", cur_buf, 1);
      run_frame(32'h0000_2000);
      check("f2_cur_buf_end", cur_buf, 1);

      // Frame 3: starvation, backpressure, overrun, enable drop.
      ovr0        = ovr_cnt;
      frame_valid = 1'b0;
      fifo_count  = 10'd1;
      cyc();
      frame_valid = 1'b1;
      cyc();
      frame_valid = 1'b0;
      #1;
      check("f3_cur_buf", cur_buf, 0);
      for (int i = 0; i < 4; i++) cyc();
      check("starve_req", req, 0);
      check("starve_busy", busy, 1);
      fifo_count = 10'd2;
      cyc();
      check("starve_release_req", req, 1);
      check("f3_addr0", addr, 32'h0000_1000);
      cyc();
      cyc();
      gnt       = 1'b1;
      wready    = 1'b1;
      fifo_dout = 32'h1111_2222;
      cyc();
      gnt = 1'b0;
      #1;
      re0 = re_cnt;
      check("bp_wvalid0", wvalid, 1);
      check("bp_re0", fifo_re, 1);
      check("bp_wdata0", wdata, 32'h1111_2222);
      cyc();
      wready    = 1'b0;
      fifo_dout = 32'h3333_4444;
      #1;
      check("bp_stall1_re", fifo_re, 0);
      check("bp_stall1_wvalid", wvalid, 1);
      check("bp_stall1_wdata", wdata, 32'h3333_4444);
      cyc();
      check("bp_stall2_re", fifo_re, 0);
      check("bp_stall2_wdata", wdata, 32'h3333_4444);
      check("bp_stall2_addr", addr, 32'h0000_1000);
      wready = 1'b1;
      #1;
      check("bp_last_re", fifo_re, 1);
      cyc();
      check("bp_end_wvalid", wvalid, 0);
      check("bp_beats", re_cnt - re0, 2);
      fifo_count = 10'd4;
      run_burst(32'h0000_1008, 1'b1);
      run_burst(32'h0000_1010, 1'b0);
      enable = 1'b0;
      run_burst(32'h0000_1018, 1'b0);
      check("f3_done_hi", frame_done, 1);
      cyc();
      check("f3_done_lo", frame_done, 0);
      check("f3_idle_busy", busy, 0);
      check("f3_ovr_count", ovr_cnt - ovr0, 1);
      frame_valid = 1'b0;
      cyc();
      frame_valid = 1'b1;
      cyc();
      cyc();
      check("idle_ignores_fs_buf", cur_buf, 0);
      check("idle_ignores_fs_busy", busy, 0);

      // Frame 4: reset mid-burst, then restart on buffer 0.
      enable      = 1'b1;
      frame_valid = 1'b0;
      cyc();
      cyc();
      frame_valid = 1'b1;
      cyc();
      check("f4_cur_buf", cur_buf, 1);
      cyc();
      check("f4_req", req, 1);
      check("f4_addr", addr, 32'h0000_2000);
      cyc();
      cyc();
      gnt = 1'b1;
      cyc();
      gnt = 1'b0;
      #1;
      check("f4_wvalid", wvalid, 1);
      RST = 1'b1;
      cyc();
      RST         = 1'b0;
      frame_valid = 1'b0;
      #1;
      check("mid_rst_req", req, 0);
      check("mid_rst_wvalid", wvalid, 0);
      check("mid_rst_fifo_re", fifo_re, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cur_buf", cur_buf, 1);
      ovr0 = ovr_cnt;
      cyc();
      cyc();
      frame_valid = 1'b1;
      cyc();
      #1;
      check("f5_cur_buf", cur_buf, 0);
      run_frame(32'h0000_1000);
      check("f5_no_ovr", ovr_cnt - ovr0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
